route_reservation_arbiter: RTL and testbench
============================================

Name: route_reservation_arbiter

Overview:
- Switch-side responder to the per-port route-reservation handshake issued by each input port's control logic.
- Each of N input ports asks to reserve one of N output ports. The block arbitrates contending requests round-robin per output and returns a level grant, routeReserveStatus.
- The reservation is held until that input pulses routeRelieve.
- The block also drives crossbar select lines, so the switch fabric routes each reserved output from its owning input.

Parameters:
- N, 4, number of input ports and number of output ports (mesh switch: 0 North, 1 South, 2 West, 3 East).
- REQUEST_WIDTH, 2, width of one output index; must equal $clog2(N).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; asserted when 0, sampled on rising clk.
- routeReserveRequestValid  input  N  bit i: input i requests a route.
- routeReserveRequest  input  N*REQUEST_WIDTH  slice i: requested output index of input i.
- routeRelieve  input  N  bit i: single-cycle pulse, input i releases its route.
- routeReserveStatus  output  N  bit i: input i currently owns its requested output (level).
- outputSelect  output  N*REQUEST_WIDTH  slice o: index of the input owning output o.
- outputSelectValid  output  N  bit o: output o is reserved.
- protocolError  output  1  sticky illegal-event flag.

Behaviour:
- State per output o: owned[o] (1 bit), owner[o] (REQUEST_WIDTH bits), rrPtr[o] (REQUEST_WIDTH bits).
- State per input i: held[i] (1 bit), heldOut[i] (REQUEST_WIDTH bits).
- Reset (rst==0 at the edge):
  - all owned/held cleared;
  - all rrPtr set to 0;
  - routeReserveStatus=0, outputSelectValid=0, outputSelect=0, protocolError=0.
  - Reset mid-reservation drops every route immediately; no relieve is needed.
- Eligible request: input i is eligible when routeReserveRequestValid[i]=1 and held[i]=0 and the requested index is < N.
- Arbitration, per output o with owned[o]=0 at the start of the cycle:
  - candidates are eligible inputs requesting o;
  - the winner is the first candidate scanning i = rrPtr[o], rrPtr[o]+1, ... modulo N.
  - On the next edge: owned[o]=1, owner[o]=winner, held[winner]=1, heldOut[winner]=o, rrPtr[o]=(winner+1) mod N.
- Latency: request sampled in cycle t, routeReserveStatus high in cycle t+1 when uncontended. Losers keep requesting and are re-arbitrated once the output frees.
- Requester contract: hold routeReserveRequestValid and routeReserveRequest stable until status rises. Status stays 1 while held.
- Relieve: routeRelieve[i]=1 with held[i]=1 clears held[i] and owned[heldOut[i]] at the next edge, so status drops at t+1.
- Freed-output timing: the freed output is arbitrable from the cycle after the clear. A relieve in cycle t and a competing request in cycle t therefore give a grant at t+2 (one bubble). This is deliberate: no same-cycle pass-through.
- Simultaneous relieve and new request on the same input in one cycle: the relieve is applied and the request is ignored. The request is re-evaluated from the next cycle.
- Outputs are registered directly from state:
  - routeReserveStatus[i]=held[i];
  - outputSelectValid[o]=owned[o];
  - outputSelect slice o = owner[o], or 0 when not owned.
- protocolError set to 1 at the next edge and held until reset on any of:
  - routeRelieve[i] while held[i]=0;
  - request index >= N (reachable only if N < 2^REQUEST_WIDTH).
  - The offending event has no other effect.
- Request while held[i]=1 is ignored silently; it is not an error, since the input may still hold valid high for one cycle after status rises.
- Invariants:
  - at most one owner per output;
  - at most one output per input;
  - owned[o]=1 implies held[owner[o]]=1 and heldOut[owner[o]]=o.

Decomposition:
- Shared package noc_route_pkg holds:
  - direction constants DIR_NORTH=0, DIR_SOUTH=1, DIR_WEST=2, DIR_EAST=3;
  - a localparam function for index width, clog2 of N.
- One sub-module is natural: rr_arbiter (N-bit request vector plus pointer in, one-hot grant plus grant-valid out, combinational). It is instantiated N times, once per output.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> all outputs 0; status stays 0 with no requests.
- Single grant and release: input 2 requests output 3 at t=5 -> status[2]=1 at t=6, outputSelect[3]=2, outputSelectValid[3]=1. routeRelieve[2] pulse at t=10 -> status[2]=0 and outputSelectValid[3]=0 at t=11.
- Contention and fairness: inputs 0, 1, 3 all request output 1 at t=5 with rrPtr=0:
  - input 0 is granted at t=6;
  - input 0 relieves at t=8, so input 1 is granted at t=10;
  - input 1 relieves at t=12, so input 3 is granted at t=14.
- Parallel non-conflicting requests: input 0 to output 3 and input 1 to output 2 in the same cycle -> both statuses 1 the next cycle, with outputSelect[3]=0 and outputSelect[2]=1.
- Errors: routeRelieve[1] with nothing held -> protocolError=1 next cycle and it stays 1. With N=3, REQUEST_WIDTH=2, a request to output 3 -> never granted, protocolError=1.
- Reset mid-operation: two routes held, rst=0 for one cycle -> all status and select outputs 0 next cycle. A fresh request after rst=1 is granted in 1 cycle.

Source files
------------

// File: rtl/noc_route_pkg.sv
// Shared definitions for the route-reservation logic: mesh direction indices
// and index-width helpers.
package noc_route_pkg;

  localparam int DIR_NORTH = 0;
  localparam int DIR_SOUTH = 1;
  localparam int DIR_WEST  = 2;
  localparam int DIR_EAST  = 3;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // An index field can encode values beyond N-1 when N is not a power of two.
  function automatic logic idx_ok(input int idx, input int n);
    return idx < n;
  endfunction

endpackage

// File: rtl/route_reservation_arbiter_if.sv
// Per-port route-reservation handshake bundle between input-port control
// logic (master) and the switch-side reservation arbiter (slave).
interface route_reservation_arbiter_if #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
);

  logic [N-1:0]               routeReserveRequestValid;
  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [N-1:0]               routeRelieve;
  logic [N-1:0]               routeReserveStatus;
  logic [N*REQUEST_WIDTH-1:0] outputSelect;
  logic [N-1:0]               outputSelectValid;
  logic                       protocolError;

  modport master (
    output routeReserveRequestValid, routeReserveRequest, routeRelieve,
    input  routeReserveStatus, outputSelect, outputSelectValid, protocolError
  );

  modport slave (
    input  routeReserveRequestValid, routeReserveRequest, routeRelieve,
    output routeReserveStatus, outputSelect, outputSelectValid, protocolError
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_valid_o
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid_o && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        gnt_valid_o                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_reservation_arbiter.sv
// Switch-side route-reservation responder: per-output round-robin grants held
// until the owning input relieves, plus crossbar select and sticky error flag.
module route_reservation_arbiter
  import noc_route_pkg::*;
#(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = idx_width(N)
) (
  input logic                        clk,
  input logic                        rst,
  route_reservation_arbiter_if.slave bus
);

  localparam int RW = REQUEST_WIDTH;

  logic [N-1:0]         owned_q, owned_d;
  logic [N-1:0][RW-1:0] owner_q, owner_d;
  logic [N-1:0][RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]         held_q, held_d;
  logic [N-1:0][RW-1:0] held_out_q, held_out_d;
  logic                 err_q, err_d;

  logic [N-1:0][RW-1:0] req_idx;
  logic [N-1:0]         idx_legal;
  logic [N-1:0][N-1:0]  cand;
  logic [N-1:0][N-1:0]  gnt;
  logic [N-1:0]         gnt_valid;

  // Only free outputs see candidates, so a relieved output waits one cycle.
  always_comb begin
    req_idx   = '0;
    idx_legal = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      req_idx[i]   = bus.routeReserveRequest[i*RW +: RW];
      idx_legal[i] = idx_ok(int'(req_idx[i]), N);
    end
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        cand[o][i] = bus.routeReserveRequestValid[i] && !held_q[i] && idx_legal[i]
                     && (int'(req_idx[i]) == o) && !owned_q[o];
      end
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_arb
    rr_arbiter #(.N(N), .PW(RW)) u_rr_arbiter (
      .req_i       (cand[o]),
      .ptr_i       (rr_ptr_q[o]),
      .gnt_o       (gnt[o]),
      .gnt_valid_o (gnt_valid[o])
    );
  end

  always_comb begin
    owned_d    = owned_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    held_d     = held_q;
    held_out_d = held_out_q;
    err_d      = err_q;

    for (int i = 0; i < N; i++) begin
      if (bus.routeRelieve[i]) begin
        if (held_q[i]) begin
          held_d[i]                = 1'b0;
          owned_d[held_out_q[i]]   = 1'b0;
          owner_d[held_out_q[i]]   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      if (bus.routeReserveRequestValid[i] && !idx_legal[i]) err_d = 1'b1;
    end

    // Grants touch only free outputs and unheld inputs, disjoint from relieves.
    for (int o = 0; o < N; o++) begin
      if (gnt_valid[o]) begin
        owned_d[o] = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (gnt[o][i]) begin
            owner_d[o]    = RW'(i);
            rr_ptr_d[o]   = RW'((i + 1) % N);
            held_d[i]     = 1'b1;
            held_out_d[i] = RW'(o);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owned_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      held_q     <= '0;
      held_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      owned_q    <= owned_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      held_q     <= held_d;
      held_out_q <= held_out_d;
      err_q      <= err_d;
    end
  end

  // owner_q is cleared on release, so it reads 0 for every unowned output.
  assign bus.routeReserveStatus = held_q;
  assign bus.outputSelectValid  = owned_q;
  assign bus.outputSelect       = owner_q;
  assign bus.protocolError      = err_q;

endmodule

// File: tb/tb_route_reservation_arbiter.sv
// Directed bench for route_reservation_arbiter: a 4-port instance for the
// main function and a 3-port instance for the out-of-range index error.
module tb_route_reservation_arbiter;
  import noc_route_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  route_reservation_arbiter_if #(.N(4), .REQUEST_WIDTH(2)) bus_a ();
  route_reservation_arbiter_if #(.N(3), .REQUEST_WIDTH(2)) bus_b ();

  route_reservation_arbiter #(.N(4), .REQUEST_WIDTH(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  route_reservation_arbiter #(.N(3), .REQUEST_WIDTH(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req_a(input int i, input int o);
    bus_a.routeReserveRequestValid[i]  = 1'b1;
    bus_a.routeReserveRequest[i*2 +: 2] = 2'(o);
  endtask

  task automatic drop_a(input int i);
    bus_a.routeReserveRequestValid[i]  = 1'b0;
    bus_a.routeReserveRequest[i*2 +: 2] = 2'b00;
  endtask

  task automatic relieve_a(input int i);
    bus_a.routeRelieve[i] = 1'b1;
    step(1);
    bus_a.routeRelieve[i] = 1'b0;
  endtask

  initial begin
    bus_a.routeReserveRequestValid = '0;
    bus_a.routeReserveRequest      = '0;
    bus_a.routeRelieve             = '0;
    bus_b.routeReserveRequestValid = '0;
    bus_b.routeReserveRequest      = '0;
    bus_b.routeRelieve             = '0;

    // Reset then idle
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    check("rst_status",    32'(bus_a.routeReserveStatus), 32'h0);
    check("rst_selvalid",  32'(bus_a.outputSelectValid),  32'h0);
    check("rst_select",    32'(bus_a.outputSelect),       32'h0);
    check("rst_error",     32'(bus_a.protocolError),      32'h0);
    step(2);
    check("idle_status",   32'(bus_a.routeReserveStatus), 32'h0);

    // Single grant: input 2 -> East; valid stays high one cycle after grant
    req_a(2, DIR_EAST);
    step(1);
    check("single_status",   32'(bus_a.routeReserveStatus), 32'b0100);
    check("single_select",   32'(bus_a.outputSelect),       32'h80);
    check("single_selvalid", 32'(bus_a.outputSelectValid),  32'b1000);
    step(1);
    drop_a(2);
    check("held_req_status", 32'(bus_a.routeReserveStatus), 32'b0100);
    check("held_req_noerr",  32'(bus_a.protocolError),      32'h0);
    step(2);

    // Relieve plus a new request on the same input: request ignored this cycle
    req_a(2, DIR_NORTH);
    relieve_a(2);
    check("relieve_status",   32'(bus_a.routeReserveStatus), 32'h0);
    check("relieve_selvalid", 32'(bus_a.outputSelectValid),  32'h0);
    check("relieve_select",   32'(bus_a.outputSelect),       32'h0);
    step(1);
    drop_a(2);
    check("rereq_status",   32'(bus_a.routeReserveStatus), 32'b0100);
    check("rereq_select",   32'(bus_a.outputSelect),       32'h02);
    check("rereq_selvalid", 32'(bus_a.outputSelectValid),  32'b0001);
    relieve_a(2);
    check("rereq_release",  32'(bus_a.routeReserveStatus), 32'h0);

    // Contention on South from inputs 0, 1, 3 with pointer at 0
    req_a(0, DIR_SOUTH);
    req_a(1, DIR_SOUTH);
    req_a(3, DIR_SOUTH);
    step(1);
    drop_a(0);
    check("cont0_status",   32'(bus_a.routeReserveStatus), 32'b0001);
    check("cont0_select",   32'(bus_a.outputSelect),       32'h00);
    check("cont0_selvalid", 32'(bus_a.outputSelectValid),  32'b0010);
    step(1);
    check("cont0_hold",     32'(bus_a.routeReserveStatus), 32'b0001);
    relieve_a(0);
    check("cont_bubble1",   32'(bus_a.routeReserveStatus), 32'h0);
    step(1);
    drop_a(1);
    check("cont1_status",   32'(bus_a.routeReserveStatus), 32'b0010);
    check("cont1_select",   32'(bus_a.outputSelect),       32'h04);
    step(1);
    relieve_a(1);
    check("cont_bubble2",   32'(bus_a.routeReserveStatus), 32'h0);
    step(1);
    drop_a(3);
    check("cont3_status",   32'(bus_a.routeReserveStatus), 32'b1000);
    check("cont3_select",   32'(bus_a.outputSelect),       32'h0C);
    relieve_a(3);
    check("cont3_release",  32'(bus_a.outputSelectValid),  32'h0);

    // Parallel non-conflicting: input 0 -> East, input 1 -> West
    req_a(0, DIR_EAST);
    req_a(1, DIR_WEST);
    step(1);
    drop_a(0);
    drop_a(1);
    check("par_status",   32'(bus_a.routeReserveStatus), 32'b0011);
    check("par_select",   32'(bus_a.outputSelect),       32'h10);
    check("par_selvalid", 32'(bus_a.outputSelectValid),  32'b1100);
    step(1);

    // Reset mid-operation drops both routes
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("midrst_status",   32'(bus_a.routeReserveStatus), 32'h0);
    check("midrst_selvalid", 32'(bus_a.outputSelectValid),  32'h0);
    check("midrst_select",   32'(bus_a.outputSelect),       32'h0);
    req_a(2, DIR_NORTH);
    step(1);
    drop_a(2);
    check("postrst_status", 32'(bus_a.routeReserveStatus), 32'b0100);
    check("postrst_select", 32'(bus_a.outputSelect),       32'h02);
    relieve_a(2);
    check("pre_err_clear",  32'(bus_a.protocolError),      32'h0);

    // Relieve with nothing held sets the sticky error
    relieve_a(1);
    check("relerr_set",    32'(bus_a.protocolError),      32'h1);
    check("relerr_status", 32'(bus_a.routeReserveStatus), 32'h0);
    step(3);
    check("relerr_sticky", 32'(bus_a.protocolError),      32'h1);

    // N=3 instance: index 3 is out of range, never granted
    check("b_pre_err", 32'(bus_b.protocolError), 32'h0);
    bus_b.routeReserveRequestValid[0] = 1'b1;
    bus_b.routeReserveRequest[1:0]    = 2'd3;
    step(1);
    check("b_idx_err",    32'(bus_b.protocolError),      32'h1);
    check("b_idx_status", 32'(bus_b.routeReserveStatus), 32'h0);
    step(2);
    check("b_idx_never",  32'(bus_b.routeReserveStatus), 32'h0);
    check("b_idx_selv",   32'(bus_b.outputSelectValid),  32'h0);
    bus_b.routeReserveRequestValid[0] = 1'b0;
    bus_b.routeReserveRequestValid[1] = 1'b1;
    bus_b.routeReserveRequest[3:2]    = 2'd2;
    step(1);
    bus_b.routeReserveRequestValid[1] = 1'b0;
    check("b_legal_status", 32'(bus_b.routeReserveStatus), 32'b010);
    check("b_legal_select", 32'(bus_b.outputSelect),       32'b01_00_00);
    check("b_err_sticky",   32'(bus_b.protocolError),      32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
